lcd_init_seq: RTL and testbench

Parametrised LCD power-on initialisation sequencer. It owns its own delay counter and drives the 4-bit LCD data nibble and the E strobe through the HD44780-style power-up nibble sequence (0x3, 0x3, 0x3, 0x2). It then asserts `enable` to hand the bus to the command/data writer. Unlike the previous init FSM, all delays are parameters, the block can be re-triggered without a reset, and it optionally issues the full configuration command set.

---
 rtl/lcd_init_seq.sv | 139 +++++++++++++
 tb/tb_lcd_init_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_seq.sv
// HD44780-style power-on nibble sequencer (0x3,0x3,0x3,0x2) with parametrised delays and re-trigger.
// Define LCD_INIT_CONFIG_EN to also send the configuration bytes 0x28, 0x06, 0x0C, 0x01.
module lcd_init_seq #(
    parameter int PWR_WAIT_CYC   = 750000,
    parameter int E_PULSE_CYC    = 12,
    parameter int WAIT_LONG_CYC  = 205000,
    parameter int WAIT_SHORT_CYC = 5000,
    parameter int WAIT_CMD_CYC   = 2000,
`ifdef LCD_INIT_CONFIG_EN
    parameter int NIB_GAP_CYC    = 50,
    parameter int CLEAR_WAIT_CYC = 82000,
`endif
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] sf_d,
    output logic       lcd_e,
    output logic       busy,
    output logic       enable
);

    typedef enum logic [2:0] {S_IDLE, S_PWR_WAIT, S_PULSE, S_GAP, S_DONE} state_t;

`ifdef LCD_INIT_CONFIG_EN
    localparam int STEP_W = 4;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(11);
`else
    localparam int STEP_W = 2;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3);
`endif

    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(WAIT_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(WAIT_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(WAIT_CMD_CYC - 1);
`ifdef LCD_INIT_CONFIG_EN
    localparam logic [CNT_W-1:0] NIB_LAST   = CNT_W'(NIB_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [3:0]          sf_d_q, sf_d_d;
    logic                lcd_e_q, lcd_e_d;
    logic                busy_q, busy_d;
    logic                enable_q, enable_d;

    logic [3:0]          step_nib;
    logic [CNT_W-1:0]    gap_last;

    // Step table: nibble driven during the pulse and length of the gap that follows it.
    always_comb begin
        step_nib = 4'h0;
        gap_last = CMD_LAST;
        case (step_q)
            STEP_W'(0):  begin step_nib = 4'h3; gap_last = LONG_LAST;  end
            STEP_W'(1):  begin step_nib = 4'h3; gap_last = SHORT_LAST; end
            STEP_W'(2):  begin step_nib = 4'h3; gap_last = CMD_LAST;   end
            STEP_W'(3):  begin step_nib = 4'h2; gap_last = CMD_LAST;   end
`ifdef LCD_INIT_CONFIG_EN
            STEP_W'(4):  begin step_nib = 4'h2; gap_last = NIB_LAST;   end
            STEP_W'(5):  begin step_nib = 4'h8; gap_last = CMD_LAST;   end
            STEP_W'(6):  begin step_nib = 4'h0; gap_last = NIB_LAST;   end
            STEP_W'(7):  begin step_nib = 4'h6; gap_last = CMD_LAST;   end
            STEP_W'(8):  begin step_nib = 4'h0; gap_last = NIB_LAST;   end
            STEP_W'(9):  begin step_nib = 4'hC; gap_last = CMD_LAST;   end
            STEP_W'(10): begin step_nib = 4'h0; gap_last = NIB_LAST;   end
            STEP_W'(11): begin step_nib = 4'h1; gap_last = CLEAR_LAST; end
`endif
            default:     begin step_nib = 4'h0; gap_last = CMD_LAST;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            sf_d_q   <= 4'h0;
            lcd_e_q  <= 1'b0;
            busy_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            sf_d_q   <= sf_d_d;
            lcd_e_q  <= lcd_e_d;
            busy_q   <= busy_d;
            enable_q <= enable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                state_d = S_PWR_WAIT;
                step_d  = '0;
            end
            S_PWR_WAIT: if (cnt_q == PWR_LAST) state_d = S_PULSE;
            S_PULSE:    if (cnt_q == PULSE_LAST) state_d = S_GAP;
            S_GAP: begin
                if (cnt_q == gap_last) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PULSE;
                        step_d  = step_q + STEP_W'(1);
                    end
                end
            end
            S_DONE:     if (start) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Every state entry restarts the count; DONE parks it at zero.
        if (state_d != state_q || state_q == S_DONE) cnt_d = '0;
    end

    // Bus pins follow the current state; handshake flags follow the next state.
    always_comb begin
        lcd_e_d  = (state_q == S_PULSE);
        sf_d_d   = lcd_e_d ? step_nib : 4'h0;
        enable_d = (state_d == S_DONE);
        busy_d   = ~enable_d;
    end

    assign sf_d   = sf_d_q;
    assign lcd_e  = lcd_e_q;
    assign busy   = busy_q;
    assign enable = enable_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq using small delay parameters; edges counted from IDLE entry (edge 0).
module tb_lcd_init_seq;

    localparam int PWR   = 10;
    localparam int EP    = 2;
    localparam int WLONG = 7;
    localparam int WSHRT = 5;
    localparam int WCMD  = 3;
`ifdef LCD_INIT_CONFIG_EN
    localparam int WNIB  = 2;
    localparam int WCLR  = 6;
    localparam int NPULSE  = 12;
    localparam int EN_EDGE = 76;
    int         ps_tab  [NPULSE] = '{12, 21, 28, 33, 38, 42, 47, 51, 56, 60, 65, 69};
    logic [3:0] nib_tab [NPULSE] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                     4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
`else
    localparam int NPULSE  = 4;
    localparam int EN_EDGE = 37;
    int         ps_tab  [NPULSE] = '{12, 21, 28, 33};
    logic [3:0] nib_tab [NPULSE] = '{4'h3, 4'h3, 4'h3, 4'h2};
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sf_d;
    logic       lcd_e;
    logic       busy;
    logic       enable;

    int checks = 0;
    int errors = 0;

    lcd_init_seq #(
        .PWR_WAIT_CYC   (PWR),
        .E_PULSE_CYC    (EP),
        .WAIT_LONG_CYC  (WLONG),
        .WAIT_SHORT_CYC (WSHRT),
        .WAIT_CMD_CYC   (WCMD),
`ifdef LCD_INIT_CONFIG_EN
        .NIB_GAP_CYC    (WNIB),
        .CLEAR_WAIT_CYC (WCLR),
`endif
        .CNT_W          (20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sf_d   (sf_d),
        .lcd_e  (lcd_e),
        .busy   (busy),
        .enable (enable)
    );

    always #5 clk = ~clk;

    // Expected {enable, busy, lcd_e, sf_d} k edges after IDLE entry.
    function automatic logic [6:0] exp_vec(input int k);
        logic       e;
        logic [3:0] n;
        e = 1'b0;
        n = 4'h0;
        for (int i = 0; i < NPULSE; i++) begin
            if (k >= ps_tab[i] && k < ps_tab[i] + EP) begin
                e = 1'b1;
                n = nib_tab[i];
            end
        end
        if (k >= EN_EDGE) return 7'b1000000;
        return {1'b0, 1'b1, e, n};
    endfunction

    // Advance one edge and sample on the following falling edge.
    task automatic step_edge(output logic [6:0] v);
        @(posedge clk);
        @(negedge clk);
        v = {enable, busy, lcd_e, sf_d};
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_edge(obs);
            checks++;
            if (obs !== 7'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, 7'b0);
            end
        end
        start = 1'b0;
        $display("test_reset: outputs held at zero during reset");
    endtask

    task automatic test_power_up();
        logic [6:0] obs;
        int         bad;
        bad = 0;
        reset = 1'b0;
        for (int k = 1; k <= EN_EDGE; k++) begin
            step_edge(obs);
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                bad++;
                $display("FAIL power_up edge %0d: got %b expected %b", k, obs, exp_vec(k));
            end
        end
        $display("test_power_up: %0d edges traced, %0d bad, enable expected at edge %0d", EN_EDGE, bad, EN_EDGE);
    endtask

    task automatic test_done_hold();
        logic [6:0] obs;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_edge(obs);
            checks++;
            if (obs !== 7'b1000000) begin
                errors++;
                $display("FAIL done_hold cycle %0d: got %b expected %b", i, obs, 7'b1000000);
            end
        end
        $display("test_done_hold: DONE held for 5 cycles without start");
    endtask

    task automatic test_restart();
        logic [6:0] obs;
        start = 1'b1;
        step_edge(obs);
        start = 1'b0;
        checks++;
        if (obs !== 7'b0100000) begin
            errors++;
            $display("FAIL restart_idle: got %b expected %b", obs, 7'b0100000);
        end
        // start pulses while busy (power wait and mid-pulse) must be ignored
        for (int k = 1; k <= EN_EDGE; k++) begin
            start = (k == 5) || (k == ps_tab[1]);
            step_edge(obs);
            start = 1'b0;
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL restart edge %0d: got %b expected %b", k, obs, exp_vec(k));
            end
        end
        $display("test_restart: rerun after start in DONE, busy-time starts ignored");
    endtask

    task automatic test_mid_reset();
        logic [6:0] obs;
        start = 1'b1;
        step_edge(obs);
        start = 1'b0;
        for (int k = 1; k <= ps_tab[1]; k++) begin
            step_edge(obs);
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL mid_reset_pre edge %0d: got %b expected %b", k, obs, exp_vec(k));
            end
        end
        reset = 1'b1;
        step_edge(obs);
        checks++;
        if (obs !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_zero: got %b expected %b", obs, 7'b0);
        end
        reset = 1'b0;
        for (int k = 1; k <= EN_EDGE; k++) begin
            step_edge(obs);
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL mid_reset_rerun edge %0d: got %b expected %b", k, obs, exp_vec(k));
            end
        end
        $display("test_mid_reset: reset mid-pulse cleared outputs, full rerun traced");
    endtask

    task automatic test_back_to_back();
        logic [6:0] obs;
        start = 1'b1;
        for (int run = 0; run < 2; run++) begin
            step_edge(obs);
            checks++;
            if (obs !== 7'b0100000) begin
                errors++;
                $display("FAIL b2b_idle run %0d: got %b expected %b", run, obs, 7'b0100000);
            end
            for (int k = 1; k <= EN_EDGE; k++) begin
                step_edge(obs);
                checks++;
                if (obs !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL b2b run %0d edge %0d: got %b expected %b", run, k, obs, exp_vec(k));
                end
            end
        end
        start = 1'b0;
        step_edge(obs);
        checks++;
        if (obs !== 7'b1000000) begin
            errors++;
            $display("FAIL b2b_release: got %b expected %b", obs, 7'b1000000);
        end
        $display("test_back_to_back: two held-start runs, enable high one cycle each");
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_done_hold();
        test_restart();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
